// File: rtl/maze_pixel_renderer_pkg.sv
// Shared tile types, palette and raster geometry for the maze renderer.
// Imported by the renderer top and by the bench model.
package maze_pkg;

  localparam logic [1:0] TILE_FLOOR = 2'd0;
  localparam logic [1:0] TILE_WALL  = 2'd1;
  localparam logic [1:0] TILE_GOAL  = 2'd2;
  localparam logic [1:0] TILE_KEY   = 2'd3;

  localparam logic [11:0] COL_FLOOR  = 12'h000;
  localparam logic [11:0] COL_WALL   = 12'h888;
  localparam logic [11:0] COL_GOAL   = 12'h0F0;
  localparam logic [11:0] COL_KEY    = 12'hFF0;
  localparam logic [11:0] COL_PLAYER = 12'hF00;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  localparam int MAP_W    = 40;
  localparam int MAP_H    = 30;

  typedef struct packed {
    logic       active;
    logic       hit;
    logic [3:0] ox;
    logic [3:0] oy;
  } px_meta_t;

  function automatic logic [11:0] tile_colour(logic [1:0] t);
    logic [11:0] c;
    c = COL_FLOOR;
    unique case (t)
      TILE_FLOOR: c = COL_FLOOR;
      TILE_WALL:  c = COL_WALL;
      TILE_GOAL:  c = COL_GOAL;
      TILE_KEY:   c = COL_KEY;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/maze_pixel_renderer_if.sv
// Game-logic side of the renderer: tile-map write port and player position.
// master = game logic, slave = renderer.
interface maze_pixel_renderer_if;
  logic        map_we;
  logic [10:0] map_addr;
  logic [1:0]  map_wdata;
  logic [5:0]  player_tx;
  logic [4:0]  player_ty;

  modport master (
    output map_we, map_addr, map_wdata,
    output player_tx, player_ty
  );

  modport slave (
    input map_we, map_addr, map_wdata,
    input player_tx, player_ty
  );
endinterface

// File: rtl/maze_pixel_renderer_tile_map_ram.sv
// 2048x2 tile map, one write and one synchronous read port.
// A same-address read/write returns the old contents; no reset on the array.
module tile_map_ram (
  input  logic        CLKOUT,
  input  logic        we_i,
  input  logic [10:0] waddr_i,
  input  logic [1:0]  wdata_i,
  input  logic [10:0] raddr_i,
  output logic [1:0]  rdata_o
);

  logic [1:0] mem_q [2048];
  logic [1:0] rdata_q;

  always_ff @(posedge CLKOUT) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/maze_pixel_renderer.sv
// Two-stage pixel colour pipeline: tile lookup on a lookahead coordinate,
// then player overlay and palette into a registered RGB word.
module maze_pixel_renderer
  import maze_pkg::*;
#(
  parameter int LOOKAHEAD = 2,
  parameter int TILE_LOG2 = 4
) (
  input  logic        CLKOUT,
  input  logic        aclr_i,
  input  logic [9:0]  HCOORD,
  input  logic [9:0]  VCOORD,
  maze_pixel_renderer_if.slave game_if,
  output logic [11:0] CSEL,
  output logic        frame_start
);

  logic [9:0]  hsum, hx, vy;
  logic [5:0]  tx;
  logic [4:0]  ty;
  logic [10:0] rd_addr;
  logic [1:0]  tile;
  logic        latch;

  px_meta_t    meta_d, meta_q;
  logic [5:0]  ptx_q;
  logic [4:0]  pty_q;
  logic        fs_q;
  logic [11:0] csel_d, csel_q;

  // Look two pixels ahead so the registered colour lines up with the VGA stage
  always_comb begin
    hsum = HCOORD + 10'(LOOKAHEAD);
    hx   = hsum;
    vy   = VCOORD;
    if (hsum >= 10'(H_TOTAL)) begin
      hx = hsum - 10'(H_TOTAL);
      vy = (VCOORD == 10'(V_TOTAL - 1)) ? '0 : VCOORD + 10'd1;
    end
  end

  assign tx      = hx[TILE_LOG2 +: 6];
  assign ty      = vy[TILE_LOG2 +: 5];
  assign rd_addr = 11'({ty, 5'd0}) + 11'({ty, 3'd0}) + 11'(tx);
  assign latch   = (HCOORD == '0) && (VCOORD == 10'(V_ACTIVE));

  always_comb begin
    meta_d        = '0;
    meta_d.active = (hx < 10'(H_ACTIVE)) && (vy < 10'(V_ACTIVE));
    meta_d.hit    = (tx == ptx_q) && (ty == pty_q);
    meta_d.ox     = hx[TILE_LOG2-1:0];
    meta_d.oy     = vy[TILE_LOG2-1:0];
  end

  tile_map_ram u_ram (
    .CLKOUT  (CLKOUT),
    .we_i    (game_if.map_we),
    .waddr_i (game_if.map_addr),
    .wdata_i (game_if.map_wdata),
    .raddr_i (rd_addr),
    .rdata_o (tile)
  );

  always_comb begin
    csel_d = COL_FLOOR;
    if (!meta_q.active) begin
      csel_d = COL_FLOOR;
    end else if (meta_q.hit &&
                 meta_q.ox >= 4'd4 && meta_q.ox <= 4'd11 &&
                 meta_q.oy >= 4'd4 && meta_q.oy <= 4'd11) begin
      csel_d = COL_PLAYER;
    end else begin
      csel_d = tile_colour(tile);
    end
  end

  // Player position only changes at the start of vertical blanking
  always_ff @(posedge CLKOUT or posedge aclr_i) begin
    if (aclr_i) begin
      meta_q <= '0;
      ptx_q  <= '0;
      pty_q  <= '0;
      fs_q   <= 1'b0;
      csel_q <= '0;
    end else begin
      meta_q <= meta_d;
      fs_q   <= latch;
      csel_q <= csel_d;
      if (latch) begin
        ptx_q <= game_if.player_tx;
        pty_q <= game_if.player_ty;
      end
    end
  end

  assign CSEL        = csel_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_maze_pixel_renderer.sv
// Bench for maze_pixel_renderer: pixel-level reference model plus
// directed probes with hand-computed colours.
module tb_maze_pixel_renderer;
  import maze_pkg::*;

  logic        CLKOUT = 1'b0;
  logic        aclr_i = 1'b0;
  logic [9:0]  HCOORD = 10'd700;
  logic [9:0]  VCOORD = 10'd500;
  logic [11:0] CSEL;
  logic        frame_start;

  maze_pixel_renderer_if gif ();

  maze_pixel_renderer dut (
    .CLKOUT      (CLKOUT),
    .aclr_i      (aclr_i),
    .HCOORD      (HCOORD),
    .VCOORD      (VCOORD),
    .game_if     (gif.slave),
    .CSEL        (CSEL),
    .frame_start (frame_start)
  );

  always #20 CLKOUT = ~CLKOUT;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [11:0] act, logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the map and player as the game sees them
  int          mmap [1200];
  int          mptx = 0;
  int          mpty = 0;
  logic [11:0] pend_c = '0;
  logic [11:0] exp_c = '0;
  logic        exp_fs = 1'b0;
  bit          chk_en = 1'b0;

  function automatic logic [11:0] pix_colour(int h, int v);
    int x, y, t;
    x = h + 2;
    y = v;
    if (x >= 800) begin
      x = x - 800;
      y = v + 1;
      if (y == 525) y = 0;
    end
    if (x >= 640 || y >= 480) return 12'h000;
    if (x / 16 == mptx && y / 16 == mpty &&
        x % 16 >= 4 && x % 16 <= 11 &&
        y % 16 >= 4 && y % 16 <= 11) return 12'hF00;
    t = mmap[(y / 16) * 40 + x / 16];
    case (t)
      0:       return 12'h000;
      1:       return 12'h888;
      2:       return 12'h0F0;
      default: return 12'hFF0;
    endcase
  endfunction

  always @(posedge CLKOUT or posedge aclr_i) begin
    if (aclr_i) begin
      pend_c <= '0;
      exp_c  <= '0;
      exp_fs <= 1'b0;
      mptx   <= 0;
      mpty   <= 0;
    end else begin
      exp_c  <= pend_c;
      pend_c <= pix_colour(int'(HCOORD), int'(VCOORD));
      exp_fs <= (HCOORD == 0 && VCOORD == 480);
      if (HCOORD == 0 && VCOORD == 480) begin
        mptx <= int'(gif.player_tx);
        mpty <= int'(gif.player_ty);
      end
      if (gif.map_we && gif.map_addr < 11'd1200)
        mmap[int'(gif.map_addr)] <= int'(gif.map_wdata);
    end
  end

  always @(negedge CLKOUT) begin
    if (chk_en) begin
      check("csel", CSEL, exp_c);
      check("fstart", {11'b0, frame_start}, {11'b0, exp_fs});
    end
  end

  function automatic logic [1:0] pat(int i);
    if (i == 0) return 2'd3;
    if (i == 79) return 2'd2;
    if (i == 41 || i == 125 || i % 7 == 3) return 2'd1;
    return 2'd0;
  endfunction

  task automatic drive(int h, int v);
    @(negedge CLKOUT);
    HCOORD = 10'(h);
    VCOORD = 10'(v);
    gif.map_we = 1'b0;
  endtask

  task automatic wr(int h, int v, int a, logic [1:0] d);
    @(negedge CLKOUT);
    HCOORD = 10'(h);
    VCOORD = 10'(v);
    gif.map_we = 1'b1;
    gif.map_addr = 11'(a);
    gif.map_wdata = d;
  endtask

  task automatic sweep(int v, int h0, int h1);
    for (int h = h0; h <= h1; h++) drive(h, v);
  endtask

  // Colour for the pixel two ahead of (h,v), seen two edges later
  task automatic probe(string name, int h, int v, logic [11:0] exp);
    drive(h, v);
    drive(700, 500);
    @(negedge CLKOUT);
    check(name, CSEL, exp);
  endtask

  initial begin
    for (int i = 0; i < 1200; i++) mmap[i] = 0;
    gif.map_we = 1'b0;
    gif.map_addr = '0;
    gif.map_wdata = '0;
    gif.player_tx = '0;
    gif.player_ty = '0;

    repeat (2) @(negedge CLKOUT);
    HCOORD = 10'd100;
    VCOORD = 10'd100;
    #3 aclr_i = 1'b1;
    chk_en = 1'b1;
    #1;
    check("rst_csel", CSEL, 12'h000);
    check("rst_fs", {11'b0, frame_start}, 12'h000);
    drive(101, 100);
    drive(700, 500);
    @(negedge CLKOUT);
    #5 aclr_i = 1'b0;
    drive(700, 500);
    drive(700, 500);
    check("post_rst", CSEL, 12'h000);

    for (int i = 0; i < 1200; i++) wr(700, 500, i, pat(i));

    sweep(16, 12, 35);
    probe("wall_16", 14, 16, 12'h888);
    probe("edge_15", 13, 16, 12'h000);
    probe("wall_31", 29, 16, 12'h888);
    probe("edge_32", 30, 16, 12'h000);

    gif.player_tx = 6'd5;
    gif.player_ty = 5'd3;
    drive(0, 480);
    drive(1, 480);
    check("fs_pulse", {11'b0, frame_start}, 12'h001);
    drive(2, 480);
    check("fs_low", {11'b0, frame_start}, 12'h000);
    probe("player", 82, 52, 12'hF00);
    probe("left_of_player", 81, 52, 12'h888);
    probe("player_br", 89, 59, 12'hF00);
    probe("right_of_player", 90, 59, 12'h888);
    sweep(52, 70, 110);

    gif.player_tx = 6'd6;
    drive(0, 100);
    probe("no_mid_change", 82, 52, 12'hF00);
    drive(0, 480);
    probe("moved_old", 82, 52, 12'h888);
    probe("moved_new", 98, 52, 12'hF00);

    probe("wrap_px0", 798, 524, 12'hFF0);
    probe("wrap_px1", 799, 10, 12'hFF0);
    probe("last_active", 637, 20, 12'h0F0);
    probe("blank_640", 638, 20, 12'h000);
    sweep(20, 630, 799);
    sweep(524, 790, 799);
    sweep(0, 0, 20);

    @(negedge CLKOUT);
    HCOORD = 10'd798;
    VCOORD = 10'd524;
    gif.map_we = 1'b1;
    gif.map_addr = 11'd0;
    gif.map_wdata = 2'd2;
    drive(700, 500);
    @(negedge CLKOUT);
    check("collide_old", CSEL, 12'hFF0);
    probe("collide_new", 798, 524, 12'h0F0);

    wr(700, 500, 1500, 2'd1);
    probe("oor_map", 318, 112, 12'h000);
    sweep(112, 300, 340);

    gif.player_tx = 6'd45;
    drive(0, 480);
    probe("oor_player", 98, 52, 12'h000);
    probe("oor_player_old", 82, 52, 12'h888);
    sweep(52, 60, 120);
    sweep(56, 0, 200);

    drive(60, 120);
    drive(61, 120);
    @(negedge CLKOUT);
    check("pre_rst", CSEL, 12'h888);
    HCOORD = 10'd62;
    #3 aclr_i = 1'b1;
    #1 check("async_rst", CSEL, 12'h000);
    drive(63, 120);
    drive(64, 120);
    @(negedge CLKOUT);
    HCOORD = 10'd65;
    #5 aclr_i = 1'b0;
    sweep(120, 66, 120);
    probe("rst_player", 2, 4, 12'hF00);
    sweep(4, 0, 40);

    repeat (3) drive(700, 500);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/maze_pixel_renderer.md
# maze_pixel_renderer

Pixel-colour generator that sits directly upstream of the VGA timing stage. On every CLKOUT cycle it takes the current scan coordinates, looks up the maze tile under a 2-pixel-lookahead coordinate in an internal tile-map RAM, and overlays the player marker. It then presents a registered 12-bit RGB word, so the VGA stage samples the colour of its current pixel. Game logic writes the map through a simple write port and updates the player position, which the block latches once per frame to avoid tearing.

## Interface
Parameters:
- LOOKAHEAD, 2: pipeline depth compensated by coordinate lookahead (fixed; the spec is written for 2).
- TILE_LOG2, 4: tile edge 16 px, giving a 40×30 tile grid over 640×480.

Ports:
- CLKOUT  in  1  pixel clock, 25 MHz.
- aclr_i  in  1  reset, asynchronous, active-high.
- HCOORD  in  10  current horizontal count, 0..799.
- VCOORD  in  10  current vertical count, 0..524.
- map_we  in  1  tile-map write strobe.
- map_addr  in  11  tile index, ty*40+tx; valid range 0..1199.
- map_wdata  in  2  tile type: 0 floor, 1 wall, 2 goal, 3 key.
- player_tx  in  6  player tile X, 0..39.
- player_ty  in  5  player tile Y, 0..29.
- CSEL  out  12  registered RGB {R,G,B} for the VGA stage.
- frame_start  out  1  one-cycle pulse at the start of vertical blanking.

## Operation
- Lookahead coordinate (combinational):
  - hx = HCOORD+2.
  - If hx ≥ 800: hx −= 800 and vy = VCOORD+1, with vy = 0 if VCOORD+1 = 525.
  - Otherwise vy = VCOORD.
- Stage 1 (registered):
  - tx = hx[9:4], ty = vy[8:4], addr = ty*40+tx, computed as (ty<<5)+(ty<<3)+tx, 11 bits.
  - Synchronous RAM read of the tile type.
  - Registers carried alongside: active = (hx<640 && vy<480), pixel offsets ox = hx[3:0], oy = vy[3:0], and hit = (tx==ptx_l && ty==pty_l).
- Stage 2 (registered, drives CSEL):
  - If !active: 12'h000.
  - Else if hit and 4 ≤ ox ≤ 11 and 4 ≤ oy ≤ 11: 12'hF00 (player).
  - Else by tile type: 0→12'h000, 1→12'h888, 2→12'h0F0, 3→12'hFF0.
- Tile-map RAM: 2048×2 bits, one write port and one read port.
  - Writes land on the CLKOUT edge when map_we=1.
  - Writes to addr ≥ 1200 land in unused space and have no effect on the display.
  - Read and write to the same address in the same cycle: the read returns the old data.
  - RAM contents are not cleared by reset (power-up floor is not required).
- Player latch: ptx_l/pty_l load player_tx/player_ty on the cycle HCOORD==0 && VCOORD==480.
  - frame_start is a registered pulse asserted the following cycle.
  - Out-of-range player values (tx > 39 or ty > 29) simply never match, so no marker is drawn.

## Timing
- Reset values:
  - CSEL = 0, frame_start = 0.
  - ptx_l = 0, pty_l = 0.
  - All stage-1 registers = 0, with active = 0.
- Latency: CSEL at edge t+2 equals the colour of (HCOORD,VCOORD) at edge t+2.
- Wrap-around:
  - HCOORD=798/799 renders pixels 0/1 of the next line.
  - At VCOORD=524 those pixels render line 0.
- A map write at cycle t is visible to any read issued at t+1 or later.
- Player position is constant across a visible frame; a change mid-frame takes effect at the next VCOORD==480 line.
- Reset mid-frame: outputs go to 0 immediately. Rendering resumes from the first post-reset coordinates after 2 cycles, with no stale colour.

## Structure
- Shared package maze_pkg holds:
  - tile type localparams (TILE_FLOOR/WALL/GOAL/KEY);
  - the palette constants COL_FLOOR/WALL/GOAL/KEY/PLAYER;
  - H_ACTIVE=640, V_ACTIVE=480, H_TOTAL=800, V_TOTAL=525, MAP_W=40, MAP_H=30.
- One sub-module: tile_map_ram (2048×2, synchronous read, read-old-on-collision), so it can be swapped for a block RAM.

## Test plan
- Reset: assert aclr_i at an arbitrary point → CSEL=0, frame_start=0. After release, CSEL=0 until active coordinates arrive.
- Write wall at addr 41 (tx=1, ty=1); sweep HCOORD 16..31 on VCOORD=16 → CSEL=12'h888 exactly when the VGA coordinates are 16..31 (2-cycle alignment); CSEL=12'h000 at 15 and 32.
- player_tx=5, player_ty=3 latched at VCOORD=480: pixel (84,52) → 12'hF00; (83,52) → the tile colour. Changing player_tx at VCOORD=100 has no effect until the next frame.
- Blanking/wrap: HCOORD=638..799 → CSEL=0 for the coordinates 640..799. Pixel 0 of line 0 after VCOORD=524 shows tile 0's colour.
- Collision: write addr 0 := 2 on the same cycle its read is issued → the old colour is shown. The next frame shows 12'h0F0.
- Out-of-range: map_addr=1500 write leaves the display unchanged; player_tx=45 → no red pixels in the frame.
